// File: rtl/clk_div_ctrl_if.sv
// Ratio-programming handshake between a configuration master and clk_div_ctrl.
// The master offers a ratio; the controller answers with ready and an illegal-ratio error pulse.
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             i_cfg_valid;
    logic [CNT_W-1:0] i_cfg_div;
    logic             o_cfg_ready;
    logic             o_cfg_err;

    modport master (
        output i_cfg_valid,
        output i_cfg_div,
        input  o_cfg_ready,
        input  o_cfg_err
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_div,
        output o_cfg_ready,
        output o_cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time programmable integer clock divider with glitch-free ratio changes at period boundaries.
// Optional CLK_DIV_CTRL_PERIOD_CNT_EN adds a saturating completed-period counter output.
module clk_div_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    clk_div_ctrl_if.slave    cfg,
    output logic             o_clk,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_div_active,
    output logic             o_busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]      o_period_cnt
`endif
);

    localparam int unsigned PCNT_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             r_err;
    logic [CNT_W-1:0] r_div;
    logic             r_pend;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_ready;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic             w_pend_nxt;
    logic [CNT_W-1:0] w_pend_div_nxt;

    logic             w_xfer;
    logic             w_legal;
    logic             w_wrap;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_xfer    = cfg.i_cfg_valid && r_ready;
    assign w_legal   = (cfg.i_cfg_div >= CNT_W'(2));
    assign w_half    = r_div >> 1;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // A wrap closes a period; only meaningful while a period is in progress.
    assign w_wrap    = (r_state != S_IDLE) && (r_cnt == (r_div - CNT_W'(1)));

    // Next-state and datapath decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_clk_nxt      = r_clk;
        w_tick_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_div_nxt      = r_div;
        w_pend_nxt     = r_pend;
        w_pend_div_nxt = r_pend_div;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (w_xfer && w_legal) begin
                    w_div_nxt = cfg.i_cfg_div;
                end
                if (i_en) begin
                    w_state_nxt = S_RUN;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end

            S_RUN, S_STOP: begin
                if (w_wrap) begin
                    // A ratio accepted on the wrap edge takes the new period directly.
                    w_cnt_nxt  = '0;
                    w_pend_nxt = 1'b0;
                    if (w_xfer && w_legal) begin
                        w_div_nxt = cfg.i_cfg_div;
                    end else if (r_pend) begin
                        w_div_nxt = r_pend_div;
                    end
                    if (i_en) begin
                        w_state_nxt = S_RUN;
                        w_clk_nxt   = 1'b1;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_clk_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_clk_nxt   = (w_cnt_inc < w_half);
                    w_state_nxt = i_en ? S_RUN : S_STOP;
                    if (w_xfer && w_legal) begin
                        w_pend_nxt     = 1'b1;
                        w_pend_div_nxt = cfg.i_cfg_div;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_clk_nxt   = 1'b0;
            end
        endcase

        if (w_xfer && !w_legal) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
            r_err      <= 1'b0;
            r_div      <= CNT_W'(DEF_DIV);
            r_pend     <= 1'b0;
            r_pend_div <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk      <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
            r_err      <= w_err_nxt;
            r_div      <= w_div_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_ready    <= !w_pend_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [PCNT_W-1:0] r_period_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period_cnt <= '0;
        end else if (w_wrap && (r_period_cnt != {PCNT_W{1'b1}})) begin
            r_period_cnt <= r_period_cnt + PCNT_W'(1);
        end
    end

    assign o_period_cnt = r_period_cnt;
`endif

    assign o_clk           = r_clk;
    assign o_tick          = r_tick;
    assign o_div_active    = r_div;
    assign o_busy          = r_busy;
    assign cfg.o_cfg_ready = r_ready;
    assign cfg.o_cfg_err   = r_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: waveform shape, reprogramming, illegal ratios, stop and reset.
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             o_clk;
    logic             o_tick;
    logic [CNT_W-1:0] o_div_active;
    logic             o_busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0]      o_period_cnt;
`endif

    int total;
    int bad;

    logic [15:0] cap_clk;
    logic [15:0] cap_tick;
    logic [15:0] cap_busy;
    logic [15:0] cap_rdy;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .cfg          (cfg_if),
        .o_clk        (o_clk),
        .o_tick       (o_tick),
        .o_div_active (o_div_active),
        .o_busy       (o_busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        ,
        .o_period_cnt (o_period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample n consecutive post-edge cycles, bit i = cycle i.
    task automatic capture(input int n);
        cap_clk  = '0;
        cap_tick = '0;
        cap_busy = '0;
        cap_rdy  = '0;
        for (int i = 0; i < n; i++) begin
            cap_clk[i]  = o_clk;
            cap_tick[i] = o_tick;
            cap_busy[i] = o_busy;
            cap_rdy[i]  = cfg_if.o_cfg_ready;
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_cfg_div   = '0;
        step();
        step();

        chk("rst_clk",   32'(o_clk), 32'd0);
        chk("rst_tick",  32'(o_tick), 32'd0);
        chk("rst_err",   32'(cfg_if.o_cfg_err), 32'd0);
        chk("rst_div",   32'(o_div_active), 32'd8);
        chk("rst_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        chk("rst_busy",  32'(o_busy), 32'd0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("rst_pcnt",  32'(o_period_cnt), 32'd0);
`endif

        // Default ratio 8: first rising o_clk one cycle after en is sampled.
        rst = 1'b0;
        en  = 1'b1;
        step();
        chk("start_clk",  32'(o_clk), 32'd1);
        chk("start_tick", 32'(o_tick), 32'd1);
        capture(16);
        chk("n8_clk",  32'(cap_clk), 32'h0F0F);
        chk("n8_tick", 32'(cap_tick), 32'h0101);

        // Stop on a period boundary.
        en = 1'b0;
        capture(8);
        chk("stop8_clk",  32'(cap_clk), 32'h000F);
        chk("stop8_tick", 32'(cap_tick), 32'h0001);
        chk("stop8_busy", 32'(cap_busy), 32'h00FF);
        chk("idle_busy",  32'(o_busy), 32'd0);
        capture(4);
        chk("idle_clk",  32'(cap_clk), 32'h0000);
        chk("idle_tick", 32'(cap_tick), 32'h0000);

        // Program N=5 in IDLE: applied on the next edge.
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd5;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        chk("idle_n5_div",   32'(o_div_active), 32'd5);
        chk("idle_n5_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        en = 1'b1;
        step();
        capture(10);
        chk("n5_clk",  32'(cap_clk), 32'h0063);
        chk("n5_tick", 32'(cap_tick), 32'h0021);

        // Back to N=8 via pending at cnt0 of an N=5 period.
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd8;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        chk("pend8_ready", 32'(cfg_if.o_cfg_ready), 32'd0);
        chk("pend8_div",   32'(o_div_active), 32'd5);
        step();
        step();
        step();
        chk("pend8_ready_cnt4", 32'(cfg_if.o_cfg_ready), 32'd0);
        chk("pend8_div_cnt4",   32'(o_div_active), 32'd5);
        step();
        chk("apply8_div",   32'(o_div_active), 32'd8);
        chk("apply8_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        chk("apply8_tick",  32'(o_tick), 32'd1);

        // N=4 offered at cnt=2; a second offer is held off while not ready.
        step();
        step();
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd4;
        step();
        chk("pend4_ready", 32'(cfg_if.o_cfg_ready), 32'd0);
        chk("pend4_div",   32'(o_div_active), 32'd8);
        cfg_if.i_cfg_div = 8'd6;
        capture(5);
        cfg_if.i_cfg_valid = 1'b0;
        chk("pend4_tail_clk",  32'(cap_clk), 32'h0001);
        chk("pend4_tail_tick", 32'(cap_tick), 32'h0000);
        chk("pend4_tail_rdy",  32'(cap_rdy), 32'h0000);
        chk("apply4_div",   32'(o_div_active), 32'd4);
        chk("apply4_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        capture(8);
        chk("n4_clk",  32'(cap_clk), 32'h0033);
        chk("n4_tick", 32'(cap_tick), 32'h0011);
        chk("n4_no_second_xfer", 32'(o_div_active), 32'd4);

        // N=8 accepted exactly on the wrap edge applies to the period starting there.
        step();
        step();
        step();
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd8;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        chk("wrapacc_div",   32'(o_div_active), 32'd8);
        chk("wrapacc_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        capture(8);
        chk("wrapacc_clk",  32'(cap_clk), 32'h000F);
        chk("wrapacc_tick", 32'(cap_tick), 32'h0001);

        // Illegal ratios 1 and 0.
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd1;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        chk("ill1_err",   32'(cfg_if.o_cfg_err), 32'd1);
        chk("ill1_div",   32'(o_div_active), 32'd8);
        chk("ill1_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        step();
        chk("ill1_err_end", 32'(cfg_if.o_cfg_err), 32'd0);
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd0;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        chk("ill0_err", 32'(cfg_if.o_cfg_err), 32'd1);
        chk("ill0_div", 32'(o_div_active), 32'd8);
        step();
        chk("ill0_err_end", 32'(cfg_if.o_cfg_err), 32'd0);
        step();
        step();
        step();
        step();
        capture(8);
        chk("ill_wave_clk",  32'(cap_clk), 32'h000F);
        chk("ill_wave_tick", 32'(cap_tick), 32'h0001);
        chk("ill_wave_rdy",  32'(cap_rdy), 32'h00FF);

        // N=6, then drop en at cnt=1: period completes 3 high / 3 low, no extra tick.
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd6;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("apply6_div",  32'(o_div_active), 32'd6);
        chk("apply6_tick", 32'(o_tick), 32'd1);
        step();
        en = 1'b0;
        capture(6);
        chk("stop6_clk",  32'(cap_clk), 32'h0003);
        chk("stop6_tick", 32'(cap_tick), 32'h0000);
        chk("stop6_busy", 32'(cap_busy), 32'h001F);
        capture(6);
        chk("stop6_idle_clk",  32'(cap_clk), 32'h0000);
        chk("stop6_idle_tick", 32'(cap_tick), 32'h0000);
        chk("stop6_idle_busy", 32'(cap_busy), 32'h0000);

        // Reset at cnt=3 with N=4 pending.
        en = 1'b1;
        step();
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_div   = 8'd4;
        step();
        cfg_if.i_cfg_valid = 1'b0;
        chk("rstpend_ready", 32'(cfg_if.o_cfg_ready), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_clk",   32'(o_clk), 32'd0);
        chk("midrst_div",   32'(o_div_active), 32'd8);
        chk("midrst_ready", 32'(cfg_if.o_cfg_ready), 32'd1);
        chk("midrst_busy",  32'(o_busy), 32'd0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("midrst_pcnt",  32'(o_period_cnt), 32'd0);
`endif
        rst = 1'b0;
        step();
        capture(16);
        chk("postrst_clk",  32'(cap_clk), 32'h0F0F);
        chk("postrst_tick", 32'(cap_tick), 32'h0101);
        chk("postrst_div",  32'(o_div_active), 32'd8);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("postrst_pcnt", 32'(o_period_cnt), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
